// File: rtl/velocity_ring_pkg.sv
// velocity_ring_pkg: fragment format, bubble constant and injector states shared by the velocity ring blocks
package velocity_ring_pkg;
    localparam int FRAG_W    = 129;
    localparam int EMPTY_BIT = 96;
    localparam int VEL_W     = 96;
    localparam int CELL_W    = 32;
    localparam logic [FRAG_W-1:0] BUBBLE = FRAG_W'(1) << EMPTY_BIT;
    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_HOLD, S_DONE} inj_state_t;
endpackage

// File: rtl/velocity_ring_injector.sv
// velocity_ring_injector: scans one cell's velocity store and injects valid entries into the ring as fragments
module velocity_ring_injector
    import velocity_ring_pkg::*;
#(
    parameter int NPART  = 256,
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CELL_W-1:0]   Cell,
    input  logic                start,
    input  logic [ADDR_W:0]     n_particles,
    output logic                mem_rd_en,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [FRAG_W-1:0]   mem_rdata,
    input  logic                slot_tick,
    output logic [FRAG_W-1:0]   reference,
    output logic [CELL_W-1:0]   reference_cell,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W:0]     sent_count
);
    localparam logic [ADDR_W:0] L_NMAX = (ADDR_W+1)'(NPART);
    inj_state_t          r_state;
    inj_state_t          w_state_nxt;
    logic [ADDR_W:0]     r_n;
    logic [ADDR_W-1:0]   r_idx;
    logic [FRAG_W-1:0]   r_ref;
    logic [CELL_W-1:0]   r_cell;
    logic                r_rd_en;
    logic                r_busy;
    logic                r_done;
    logic [ADDR_W:0]     r_sent;
    logic [ADDR_W:0]     w_n_clamp;
    logic                w_last;
    logic                w_accept;
    logic                w_load;
    logic                w_step;
    logic                w_unused_cell;
    assign w_unused_cell = ^Cell;
    assign w_n_clamp = (n_particles > L_NMAX) ? L_NMAX : n_particles;
    assign w_last    = ({1'b0, r_idx} + (ADDR_W+1)'(1)) == r_n;
    assign w_accept  = (r_state == S_HOLD) && slot_tick;
    assign w_load    = (r_state == S_WAIT) && mem_rdata[FRAG_W-1];
    assign w_step    = w_accept || ((r_state == S_WAIT) && !mem_rdata[FRAG_W-1]);
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = start ? ((w_n_clamp == '0) ? S_DONE : S_READ) : S_IDLE;
            S_READ:  w_state_nxt = S_WAIT;
            S_WAIT:  w_state_nxt = mem_rdata[FRAG_W-1] ? S_HOLD : (w_last ? S_DONE : S_READ);
            S_HOLD:  w_state_nxt = slot_tick ? (w_last ? S_DONE : S_READ) : S_HOLD;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_n     <= '0;
            r_idx   <= '0;
            r_ref   <= BUBBLE;
            r_cell  <= '0;
            r_rd_en <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sent  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rd_en <= w_state_nxt == S_READ;
            r_busy  <= w_state_nxt != S_IDLE;
            r_done  <= w_state_nxt == S_DONE;
            if ((r_state == S_IDLE) && start) begin
                r_n    <= w_n_clamp;
                r_idx  <= '0;
                r_sent <= '0;
            end
            if (w_step)
                r_idx <= r_idx + ADDR_W'(1);
            if (w_load) begin
                r_ref  <= {32'(r_idx), 1'b0, mem_rdata[VEL_W-1:0]};
                r_cell <= mem_rdata[VEL_W +: CELL_W];
            end
            // an accepted fragment is replaced by a bubble until the next one is read
            if (w_accept) begin
                r_sent <= r_sent + (ADDR_W+1)'(1);
                r_ref  <= BUBBLE;
                r_cell <= '0;
            end
        end
    end
    assign mem_rd_en      = r_rd_en;
    assign mem_addr       = r_idx;
    assign reference      = r_ref;
    assign reference_cell = r_cell;
    assign busy           = r_busy;
    assign done           = r_done;
    assign sent_count     = r_sent;
endmodule

// File: tb/tb_velocity_ring_injector.sv
// tb_velocity_ring_injector: directed self-checking bench for the velocity ring injector
module tb_velocity_ring_injector;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  Cell = 32'h0000_0042;
    logic         start = 1'b0;
    logic [8:0]   n_particles = '0;
    logic         mem_rd_en;
    logic [7:0]   mem_addr;
    logic [128:0] mem_rdata = '0;
    logic         slot_tick = 1'b0;
    logic [128:0] reference;
    logic [31:0]  reference_cell;
    logic         busy;
    logic         done;
    logic [8:0]   sent_count;

    logic [128:0] mem [0:255];
    int n_pass = 0, n_total = 0;
    int done_cnt = 0, rd_cnt = 0, last_addr = -1;
    int acc[$];

    velocity_ring_injector #(.NPART(256), .ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .Cell(Cell), .start(start), .n_particles(n_particles),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .slot_tick(slot_tick), .reference(reference), .reference_cell(reference_cell),
        .busy(busy), .done(done), .sent_count(sent_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
        if (done) done_cnt++;
        if (mem_rd_en) begin rd_cnt++; last_addr = int'(mem_addr); end
        if (slot_tick && !reference[96]) acc.push_back(int'(reference[128:97]));
    end

    function automatic logic [128:0] mk(input logic v, input int a);
        logic [31:0] u = a;
        return {v, u + 32'hC000_0000, u + 32'h3000, u + 32'h2000, u + 32'h1000};
    endfunction

    function automatic logic [128:0] ef(input int a);
        logic [31:0] u = a;
        return {u, 1'b0, u + 32'h3000, u + 32'h2000, u + 32'h1000};
    endfunction

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic go(input int n);
        n_particles = 9'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic serve(input int a, input int hold);
        int k = 0;
        while (reference[96] && k < 64) begin @(negedge clk); k++; end
        chk("frag_seen", k < 64, 1);
        chk("frag", reference, ef(a));
        chk("frag_cell", reference_cell, 32'hC000_0000 + a);
        repeat (hold) @(negedge clk);
        chk("frag_held", reference, ef(a));
        slot_tick = 1'b1;
        @(negedge clk);
        slot_tick = 1'b0;
        chk("bubble_after_tick", {reference[96], reference_cell}, {1'b1, 32'h0});
    endtask

    task automatic wait_done(input int limit);
        int k = 0;
        while (!done && k < limit) begin @(negedge clk); k++; end
        chk("done_seen", done, 1);
        @(negedge clk);
        chk("done_pulse_idle", {done, busy}, 2'b00);
    endtask

    initial begin
        int d0;
        for (int i = 0; i < 256; i++) mem[i] = mk(1'b0, i);
        repeat (2) @(negedge clk);
        chk("rst_ref", reference, {32'h0, 1'b1, 96'h0});
        chk("rst_outs", {reference_cell, mem_rd_en, mem_addr, busy, done, sent_count},
            {32'h0, 1'b0, 8'h0, 1'b0, 1'b0, 9'h0});
        reset = 1'b0;
        @(negedge clk);

        // scan of three valid entries, slow ticks
        for (int i = 0; i < 3; i++) mem[i] = mk(1'b1, i);
        acc.delete(); d0 = done_cnt;
        go(3);
        chk("t1_read", {mem_rd_en, mem_addr, busy}, {1'b1, 8'h0, 1'b1});
        @(negedge clk);
        chk("t1_wait", {mem_rd_en, reference[96]}, 2'b01);
        @(negedge clk);
        chk("t1_first_frag_c3", reference, ef(0));
        serve(0, 16);
        serve(1, 16);
        serve(2, 16);
        chk("t1_done_next", done, 1);
        wait_done(4);
        chk("t1_sent", sent_count, 3);
        chk("t1_order", {acc.size(), acc[0], acc[1], acc[2]}, {32'd3, 32'd0, 32'd1, 32'd2});
        chk("t1_one_done", done_cnt - d0, 1);

        // skips of invalid entries 1 and 2
        mem[0] = mk(1'b1, 0); mem[1] = mk(1'b0, 1); mem[2] = mk(1'b0, 2); mem[3] = mk(1'b1, 3);
        acc.delete();
        go(4);
        serve(0, 2);
        chk("t2_bubble_gap", reference[96], 1);
        serve(3, 0);
        wait_done(4);
        chk("t2_sent", sent_count, 2);
        chk("t2_order", {acc.size(), acc[0], acc[1]}, {32'd2, 32'd0, 32'd3});

        // empty scan
        rd_cnt = 0; d0 = done_cnt;
        go(0);
        chk("t3_empty_done_c1", {done, mem_rd_en}, 2'b10);
        @(negedge clk);
        chk("t3_empty_idle", {done, busy, rd_cnt, sent_count}, {1'b0, 1'b0, 32'd0, 9'd0});

        // clamped scan, all entries invalid
        for (int i = 0; i < 256; i++) mem[i] = mk(1'b0, i);
        rd_cnt = 0; acc.delete();
        go(300);
        wait_done(2000);
        chk("t3_clamp_reads", rd_cnt, 256);
        chk("t3_clamp_last_addr", last_addr, 255);
        chk("t3_clamp_sent", {sent_count, acc.size()}, {9'd0, 32'd0});
        chk("t3_done_count", done_cnt - d0, 2);

        // reset during HOLD
        mem[0] = mk(1'b1, 0); mem[1] = mk(1'b1, 1);
        go(2);
        repeat (2) @(negedge clk);
        chk("t4_in_hold", reference, ef(0));
        d0 = done_cnt;
        #2 reset = 1'b1;
        #1;
        chk("t4_rst_now", {reference[96], busy, mem_rd_en, done, reference_cell}, {4'b1000, 32'h0});
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("t4_no_done", {done_cnt - d0, busy}, {32'd0, 1'b0});
        rd_cnt = 0; acc.delete();
        go(1);
        chk("t4_restart_addr0", {mem_rd_en, mem_addr}, {1'b1, 8'h0});
        serve(0, 1);
        wait_done(4);
        chk("t4_sent", {sent_count, acc.size()}, {9'd1, 32'd1});

        // start while busy and tick while waiting are ignored
        acc.delete();
        go(2);
        n_particles = 9'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; slot_tick = 1'b1;
        @(negedge clk);
        slot_tick = 1'b0;
        chk("t5_tick_ignored", {reference, acc.size()}, {ef(0), 32'd0});
        serve(0, 3);
        serve(1, 1);
        wait_done(4);
        chk("t5_sent", sent_count, 2);
        chk("t5_order", {acc.size(), acc[0], acc[1]}, {32'd2, 32'd0, 32'd1});
        @(negedge clk);
        chk("t5_sent_held", {sent_count, busy}, {9'd2, 1'b0});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/velocity_ring_injector.md
# velocity_ring_injector

Launches one cell's particle velocities into the velocity ring as fragments on a ring node's `reference`/`reference_cell` input. It walks the cell's velocity store in index order and presents one fragment per ring slot, holding it until the node signals that the slot was consumed. It skips empty store entries and drives a bubble whenever it has nothing to send. One instance sits beside each ring node and is the transmit end of the fragment protocol that the node routes to `fragment_out` or to `next`.

## Interface
Parameters:
- `NPART`, 256: store depth, the maximum number of particles per cell.
- `ADDR_W`, 8: store address width; NPART ≤ 2^ADDR_W.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high.
- `Cell`  in  32  own cell id; unused by routing, reported for debug only.
- `start`  in  1  one-cycle pulse; begins a scan. Ignored unless IDLE.
- `n_particles`  in  ADDR_W+1  number of store entries to scan; sampled on `start`; values > NPART are clamped to NPART.
- `mem_rd_en`  out  1  store read strobe.
- `mem_addr`  out  ADDR_W  store read address.
- `mem_rdata`  in  129  {valid[128], dest_cell[127:96], vz[95:64], vy[63:32], vx[31:0]}; valid the cycle after `mem_rd_en`.
- `slot_tick`  in  1  ring node consumed the `reference` sample this cycle.
- `reference`  out  129  fragment: addr[128:97], empty flag[96], velocity[95:0].
- `reference_cell`  out  32  destination cell of the fragment.
- `busy`  out  1  high whenever not IDLE.
- `done`  out  1  one-cycle pulse at the end of a scan.
- `sent_count`  out  ADDR_W+1  number of fragments accepted in the current or last scan.

## Operation
- Bubble: `reference` = {32'b0, 1'b1, 96'b0}, `reference_cell` = 0. Bit 96 = 1 always means "no fragment".
- FSM states: IDLE, READ, WAIT, HOLD, DONE.
- IDLE, on `start`: latch n = min(n_particles, NPART), set idx = 0, clear `sent_count`. Go to DONE if n = 0, otherwise go to READ.
- READ: assert `mem_rd_en` with `mem_addr` = idx for exactly one cycle. Go to WAIT.
- WAIT: sample `mem_rdata`.
  - valid = 1: register the fragment {32'(idx), 1'b0, velocity} and dest_cell into the outputs. Go to HOLD.
  - valid = 0: skip the entry; increment idx. Go to DONE if idx+1 = n, otherwise go to READ.
- HOLD: outputs stay stable until `slot_tick`. On `slot_tick`: increment `sent_count` and idx, and set the outputs to bubble on the next cycle. Go to DONE if idx+1 = n, otherwise go to READ.
- DONE: pulse `done` for one cycle. Go to IDLE.
- `slot_tick` outside HOLD is ignored.
- `start` while busy is ignored.
- `sent_count` holds its value after DONE until the next accepted `start`.

## Timing
- Reset values: state IDLE; `reference` and `reference_cell` bubble; `mem_rd_en` 0; `mem_addr` 0; `busy` 0; `done` 0; `sent_count` 0.
- Reset asserted mid-scan: everything above takes effect immediately. Any fragment in flight is dropped and no `done` is produced.
- `start` in cycle 0 → READ in cycle 1 → first valid fragment visible from cycle 3.
- Minimum cost per sent fragment: READ + WAIT + one HOLD cycle = 3 cycles, when `slot_tick` is already high on the first HOLD cycle.
- `slot_tick` in the same cycle that HOLD is entered has no effect. HOLD is entered at the clock edge, and the tick is only sampled while in HOLD.
- `done` is registered; it rises exactly one cycle after the last accept or skip.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `velocity_ring_pkg`:
  - constants: FRAG_W = 129, EMPTY_BIT = 96, VEL_W = 96, CELL_W = 32.
  - the bubble constant.
  - the state enumeration.
  - this package also serves the ring node and the downstream fragment writer.
- No sub-module needed; the block is a single FSM plus datapath registers.

## Test plan
- Scan with no skips: n = 3, all entries valid, `slot_tick` every 16 cycles → three fragments with addr 0, 1, 2 in order; each held until its tick; `sent_count` = 3; one `done`.
- Skip handling: n = 4, entries 1 and 2 invalid → only addr 0 and 3 emitted; `sent_count` = 2; bubble between fragments.
- Empty and clamped scans: n = 0 → `done` in cycle 1 with no `mem_rd_en`. n = 300 with NPART = 256 → last `mem_addr` = 255.
- Reset mid-HOLD: assert `reset` during HOLD → in the same cycle `reference[96]` = 1, `busy` = 0, and no `done`. A subsequent `start` scans from addr 0.
- `start` while busy, and `slot_tick` while in WAIT → both ignored; the fragment sequence is unchanged.
